// File: rtl/layer_sequencer_pkg.sv
// Shared types and constants for the dense-layer sequencing slice.
// Holds the sequencer state encoding, the default latency counter width and
// the datapath types shared with the layer modules.
package layer_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUTPUT
    } sequencer_state;

    localparam int DEFAULT_LATENCY_WIDTH = 16;

    typedef logic signed [15:0] fixed_point;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_RELU,
        ACT_SIGMOID
    } activation_type;

    // Width of a layer index; a single-layer chain still needs one bit.
    function automatic int index_width(input int layers);
        return (layers > 1) ? $clog2(layers) : 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the sequencer, its request source, the layer
// chain and the downstream consumer. The master modport is the sequencer side.
interface layer_sequencer_if #(
    parameter int NUM_LAYERS = 3
);

    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_LAYERS-1:0] layer_start;
    logic [NUM_LAYERS-1:0] layer_done;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  in_valid,
        output in_ready,
        output layer_start,
        input  layer_done,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output in_valid,
        input  in_ready,
        input  layer_start,
        output layer_done,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/layer_sequencer_saturating_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
// A clear restarts the count; if enable is also high the restart counts as
// the first cycle, so the value becomes 1 rather than 0.
module layer_sequencer_saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX_VALUE = '1;

    // Restart on clear, otherwise count up until the ceiling is reached.
    always_ff @(posedge clock) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= enable ? WIDTH'(1) : '0;
        end else if (enable && (value != MAX_VALUE)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences a chain of dense layers for one inference at a time: accepts a
// request, pulses each layer's start in order, waits for its done, then
// holds the result valid until the consumer takes it. Also records the
// accept-to-valid latency of the previous inference.
// Optional watchdog: define LAYER_SEQUENCER_WATCHDOG_EN to abort a layer that
// never finishes within TIMEOUT_CYCLES and raise a sticky error.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS     = 3,
    parameter int LATENCY_WIDTH  = DEFAULT_LATENCY_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                         clock,
    input  logic                                         reset,
    layer_sequencer_if.master                            bus,
    output logic                                         busy,
    output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] current_layer,
    output logic [LATENCY_WIDTH-1:0]                     last_latency,
    output logic                                         error
);

    localparam int INDEX_WIDTH = index_width(NUM_LAYERS);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_LAYERS - 1);

    sequencer_state           state;
    sequencer_state           next_state;
    logic [INDEX_WIDTH-1:0]   index;
    logic                     accept;
    logic                     active_done;
    logic                     last_layer;
    logic                     finish;
    logic                     timeout;
    logic [LATENCY_WIDTH-1:0] latency_value;

    assign accept        = (state == IDLE) && bus.in_valid;
    assign active_done   = bus.layer_done[index];
    assign last_layer    = (index == LAST_INDEX);
    assign finish        = (state == WAIT) && active_done && last_layer;
    assign current_layer = index;

    layer_sequencer_saturating_counter #(
        .WIDTH (LATENCY_WIDTH)
    ) latency_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (accept || (state == START) || (state == WAIT)),
        .value  (latency_value)
    );

`ifdef LAYER_SEQUENCER_WATCHDOG_EN
    localparam int WATCHDOG_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [WATCHDOG_WIDTH-1:0] watchdog_value;

    layer_sequencer_saturating_counter #(
        .WIDTH (WATCHDOG_WIDTH)
    ) watchdog_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == START),
        .enable (state == WAIT),
        .value  (watchdog_value)
    );

    // The counter holds the number of completed WAIT cycles, so the limit
    // trips on the last permitted WAIT cycle when done is still absent.
    assign timeout = (state == WAIT) && !active_done &&
                     (watchdog_value >= WATCHDOG_WIDTH'(TIMEOUT_CYCLES - 1));

    // Sticky error: only a reset clears it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            error <= 1'b0;
        end else if (timeout) begin
            error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; done is only looked at in WAIT so a level left over
    // from a previous run cannot be mistaken for completion.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    next_state = START;
                end
            end
            START: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (active_done) begin
                    next_state = last_layer ? OUTPUT : START;
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Moore outputs, all forced low while reset is asserted.
    always_comb begin
        bus.in_ready    = 1'b0;
        bus.layer_start = '0;
        bus.out_valid   = 1'b0;
        busy            = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    bus.in_ready = 1'b1;
                end
                START: begin
                    bus.layer_start = NUM_LAYERS'(1) << index;
                    busy            = 1'b1;
                end
                WAIT: begin
                    busy = 1'b1;
                end
                OUTPUT: begin
                    bus.out_valid = 1'b1;
                    busy          = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

    // Active layer index: restarts at each accepted request or abort and
    // advances when a non-final layer reports done.
    always_ff @(posedge clock) begin
        if (!reset) begin
            index <= '0;
        end else if (accept || timeout) begin
            index <= '0;
        end else if ((state == WAIT) && active_done && !last_layer) begin
            index <= index + 1'b1;
        end
    end

    // Capture the latency as the sequencer moves into OUTPUT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_latency <= '0;
        end else if (finish) begin
            last_latency <= latency_value;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: a three-layer instance driven by a
// table of vectors plus randomized runs, a single-layer narrow-latency
// instance for saturation, and a short-timeout instance for the watchdog
// (exercised when LAYER_SEQUENCER_WATCHDOG_EN is defined).
module tb_layer_sequencer;

    localparam int N   = 3;
    localparam int W   = 16;
    localparam int TMO = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    layer_sequencer_if #(.NUM_LAYERS(N)) bus  ();
    layer_sequencer_if #(.NUM_LAYERS(1)) bus1 ();
    layer_sequencer_if #(.NUM_LAYERS(N)) bus2 ();

    logic          busy,  busy1,  busy2;
    logic [1:0]    current_layer, current_layer2;
    logic [0:0]    current_layer1;
    logic [W-1:0]  last_latency, last_latency2;
    logic [3:0]    last_latency1;
    logic          error, error1, error2;

    layer_sequencer #(.NUM_LAYERS(N), .LATENCY_WIDTH(W), .TIMEOUT_CYCLES(1024)) dut (
        .clock (clock), .reset (reset), .bus (bus), .busy (busy),
        .current_layer (current_layer), .last_latency (last_latency), .error (error)
    );

    layer_sequencer #(.NUM_LAYERS(1), .LATENCY_WIDTH(4), .TIMEOUT_CYCLES(1024)) dut1 (
        .clock (clock), .reset (reset), .bus (bus1), .busy (busy1),
        .current_layer (current_layer1), .last_latency (last_latency1), .error (error1)
    );

    layer_sequencer #(.NUM_LAYERS(N), .LATENCY_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut2 (
        .clock (clock), .reset (reset), .bus (bus2), .busy (busy2),
        .current_layer (current_layer2), .last_latency (last_latency2), .error (error2)
    );

    typedef struct {
        int           d [N];
        int           hold;
        logic [N-1:0] force_mask;
        logic [W-1:0] exp_latency;
    } vector_t;

    int checks   = 0;
    int failures = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference latency: each layer costs its START cycle plus its WAIT
    // cycles, saturating at the counter ceiling.
    function automatic logic [W-1:0] model_latency(input int d [N]);
        longint total = 0;
        for (int k = 0; k < N; k++) total += 1 + d[k];
        if (total > (2 ** W) - 1) total = (2 ** W) - 1;
        return W'(total);
    endfunction

    // One full inference on the three-layer instance. d[k] is the WAIT cycle
    // in which layer k reports done; force_mask holds other done bits high.
    task automatic apply_stimulus(input int d [N], input int hold,
                                  input logic [N-1:0] force_mask,
                                  input logic [W-1:0] exp_latency);
        @(negedge clock);
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        bus.layer_done = N'($urandom);
        #1;
        check_output("idle_in_ready", 32'(bus.in_ready), 1);
        check_output("idle_start", 32'(bus.layer_start), 0);
        check_output("idle_busy", 32'(busy), 0);
        for (int k = 0; k < N; k++) begin
            @(negedge clock);
            bus.in_valid   = 1'($urandom);
            bus.layer_done = N'($urandom) | force_mask | (N'(1) << k);
            #1;
            check_output("start_pulse", 32'(bus.layer_start), 32'(1) << k);
            check_output("start_in_ready", 32'(bus.in_ready), 0);
            check_output("start_layer", 32'(current_layer), 32'(k));
            for (int j = 1; j <= d[k]; j++) begin
                @(negedge clock);
                bus.in_valid      = 1'($urandom);
                bus.layer_done    = N'($urandom) | force_mask;
                bus.layer_done[k] = (j == d[k]);
                #1;
                check_output("wait_start", 32'(bus.layer_start), 0);
                check_output("wait_layer", 32'(current_layer), 32'(k));
                check_output("wait_out_valid", 32'(bus.out_valid), 0);
                check_output("wait_busy", 32'(busy), 1);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clock);
            bus.in_valid   = (hold > 0) ? 1'b1 : 1'($urandom);
            bus.out_ready  = (h == hold);
            bus.layer_done = N'($urandom);
            #1;
            check_output("out_valid", 32'(bus.out_valid), 1);
            check_output("out_in_ready", 32'(bus.in_ready), 0);
            check_output("out_start", 32'(bus.layer_start), 0);
            check_output("last_latency", 32'(last_latency), 32'(exp_latency));
        end
    endtask

    // One inference on the single-layer, 4-bit-latency instance.
    task automatic run_single(input int d, input logic [3:0] exp_latency);
        @(negedge clock);
        bus1.in_valid = 1'b1;
        #1;
        check_output("single_in_ready", 32'(bus1.in_ready), 1);
        @(negedge clock);
        bus1.in_valid   = 1'b0;
        bus1.layer_done = 1'b1;
        #1;
        check_output("single_start", 32'(bus1.layer_start), 1);
        check_output("single_layer", 32'(current_layer1), 0);
        for (int j = 1; j <= d; j++) begin
            @(negedge clock);
            bus1.layer_done = (j == d);
            #1;
            check_output("single_wait_start", 32'(bus1.layer_start), 0);
            check_output("single_busy", 32'(busy1), 1);
        end
        @(negedge clock);
        bus1.layer_done = 1'b0;
        bus1.out_ready  = 1'b1;
        #1;
        check_output("single_out_valid", 32'(bus1.out_valid), 1);
        check_output("single_latency", 32'(last_latency1), 32'(exp_latency));
        @(negedge clock);
        bus1.out_ready = 1'b0;
        #1;
        check_output("single_idle", 32'(bus1.out_valid), 0);
        check_output("single_error", 32'(error1), 0);
    endtask

    vector_t vectors [3];
    vector_t rv;

    initial begin
        bus.in_valid = 0;  bus.out_ready = 0;  bus.layer_done = '0;
        bus1.in_valid = 0; bus1.out_ready = 0; bus1.layer_done = '0;
        bus2.in_valid = 0; bus2.out_ready = 0; bus2.layer_done = '0;

        vectors[0] = '{d: '{1, 1, 1},  hold: 0, force_mask: 3'b000, exp_latency: 16'd6};
        vectors[1] = '{d: '{1, 10, 1}, hold: 0, force_mask: 3'b001, exp_latency: 16'd15};
        vectors[2] = '{d: '{3, 2, 5},  hold: 5, force_mask: 3'b110, exp_latency: 16'd13};

        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_output("reset_in_ready", 32'(bus.in_ready), 0);
        check_output("reset_start", 32'(bus.layer_start), 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("post_reset_in_ready", 32'(bus.in_ready), 1);
        check_output("post_reset_start", 32'(bus.layer_start), 0);
        check_output("post_reset_out_valid", 32'(bus.out_valid), 0);
        check_output("post_reset_latency", 32'(last_latency), 0);
        check_output("post_reset_busy", 32'(busy), 0);
        check_output("post_reset_error", 32'(error), 0);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(vectors[i].d, vectors[i].hold, vectors[i].force_mask,
                           vectors[i].exp_latency);
        end

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) rv.d[k] = int'($urandom_range(1, 6));
            rv.hold       = int'($urandom_range(0, 3));
            rv.force_mask = N'($urandom);
            apply_stimulus(rv.d, rv.hold, rv.force_mask, model_latency(rv.d));
        end

        // Reset while waiting on layer 1 abandons the inference.
        @(negedge clock);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.layer_done = '0;
        @(negedge clock);
        bus.in_valid = 1'b0;
        @(negedge clock);
        bus.layer_done = 3'b001;
        @(negedge clock);
        bus.layer_done = 3'b000;
        @(negedge clock);
        #1;
        check_output("abort_layer", 32'(current_layer), 1);
        check_output("abort_busy", 32'(busy), 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("abort_reset_in_ready", 32'(bus.in_ready), 0);
        check_output("abort_reset_busy", 32'(busy), 0);
        @(negedge clock);
        reset = 1'b1;
        bus.layer_done = '1;
        #1;
        check_output("abort_idle_in_ready", 32'(bus.in_ready), 1);
        check_output("abort_idle_layer", 32'(current_layer), 0);
        check_output("abort_idle_busy", 32'(busy), 0);
        check_output("abort_latency", 32'(last_latency), 0);
        repeat (5) begin
            @(negedge clock);
            #1;
            check_output("abort_no_start", 32'(bus.layer_start), 0);
            check_output("abort_no_out_valid", 32'(bus.out_valid), 0);
        end
        bus.layer_done = '0;

        run_single(1, 4'd2);
        run_single(13, 4'd14);
        run_single(20, 4'd15);

`ifdef LAYER_SEQUENCER_WATCHDOG_EN
        // Layer 0 never finishes; the short-timeout instance must abort.
        @(negedge clock);
        bus2.in_valid = 1'b1;
        @(negedge clock);
        bus2.in_valid   = 1'b0;
        bus2.layer_done = 3'b110;
        #1;
        check_output("wd_start", 32'(bus2.layer_start), 1);
        for (int j = 1; j <= TMO; j++) begin
            @(negedge clock);
            #1;
            check_output("wd_wait_error", 32'(error2), 0);
            check_output("wd_wait_busy", 32'(busy2), 1);
        end
        @(negedge clock);
        #1;
        check_output("wd_error", 32'(error2), 1);
        check_output("wd_in_ready", 32'(bus2.in_ready), 1);
        check_output("wd_layer", 32'(current_layer2), 0);
        check_output("wd_latency", 32'(last_latency2), 0);
        repeat (3) begin
            @(negedge clock);
            #1;
            check_output("wd_no_out_valid", 32'(bus2.out_valid), 0);
            check_output("wd_sticky", 32'(error2), 1);
        end
`else
        check_output("no_wd_error", 32'(error2), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controls a chain of NUM_LAYERS dense layers.
- Accepts one inference request through a valid/ready handshake, then starts each layer in order with a one-cycle start pulse and waits for that layer's done before starting the next.
- Presents completion to the downstream consumer through a valid/ready handshake.
- Sits between the input-capture logic and the top-level network wrapper, and also measures per-inference latency.

Parameters:
- NUM_LAYERS, 3, number of sequenced layers; must be ≥1.
- LATENCY_WIDTH, 16, width of the latency counter.
- TIMEOUT_CYCLES, 1024, per-layer watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  inference request.
- in_ready  out  1  sequencer can accept a request.
- layer_start  out  NUM_LAYERS  one-hot start pulse; bit k drives layer k's inputs_ready.
- layer_done  in  NUM_LAYERS  bit k is layer k's outputs_ready (level).
- out_valid  out  1  final layer complete; results stable.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in START, WAIT and OUTPUT.
- current_layer  out  max(1,$clog2(NUM_LAYERS))  index of the active layer.
- last_latency  out  LATENCY_WIDTH  cycles from request accept to out_valid of the previous inference.
- error  out  1  sticky timeout flag; tied 0 when the optional feature is absent.

Behaviour:
- Reset (reset==0 at an edge), effective the next cycle:
  - state=IDLE, index=0.
  - layer_start=0, out_valid=0, busy=0, in_ready=0 during reset, then 1 in IDLE.
  - last_latency=0, error=0, latency counter=0.
- Reset mid-operation abandons the inference. No start pulse or out_valid is emitted after reset is sampled.
- FSM states: IDLE, START, WAIT, OUTPUT.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready. On accept: index=0, latency counter=1, next state START.
- START (exactly 1 cycle):
  - layer_start[index]=1; all other bits 0.
  - layer_done is ignored this cycle, so a stale done level from the previous inference is never accepted.
  - Next state WAIT.
- WAIT:
  - layer_start=0.
  - When layer_done[index]==1: if index==NUM_LAYERS-1, go to OUTPUT; otherwise index++ and go to START.
  - Done bits of non-active layers are ignored.
  - Done may be accepted in the first WAIT cycle.
- OUTPUT:
  - out_valid=1, held until out_ready is sampled high, then go to IDLE.
  - On entering OUTPUT, last_latency is loaded with the counter value. Request accept counts as cycle 1; the counter saturates at 2^LATENCY_WIDTH−1 and never wraps.
- in_ready=0 in all non-IDLE states, so requests during an inference are back-pressured, not dropped.
- Minimum latency (every done asserted in the first WAIT cycle): accept → out_valid = 2·NUM_LAYERS cycles.
- NUM_LAYERS=1: index stays 0; START→WAIT→OUTPUT.
- Simultaneous events:
  - out_ready and in_valid together in OUTPUT: the new request is not accepted until the IDLE cycle (no bypass).
- current_layer equals index in every state.

Optional Feature:
- Macro: LAYER_SEQUENCER_WATCHDOG_EN.
- Defined:
  - A counter clears on START and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without the active done, error is set (sticky until reset), the state returns to IDLE, index=0, and no out_valid is produced for that inference.
  - last_latency is unchanged.
- Undefined: no watchdog logic; error tied 0; WAIT waits indefinitely.

Decomposition:
- Shared package (include.svh): sequencer_state typedef enum {IDLE, START, WAIT, OUTPUT} and default LATENCY_WIDTH constant, alongside existing fixed_point and activation_type.
- One natural sub-module: saturating_counter (parameter WIDTH; clear, enable, value). Used for the latency counter and reused for the watchdog.

Test Plan:
- Reset then idle, NUM_LAYERS=3 → in_ready=1, layer_start=000, out_valid=0, last_latency=0.
- Request; every done asserted in the first WAIT cycle → start pulses 001, 010, 100 each for one cycle, 2 cycles apart; out_valid at cycle 6; last_latency=6.
- Layer 1 done delayed 10 cycles; layer_done[0] held high throughout → layer_start[2] only after layer_done[1]; stale done bits ignored; last_latency=15.
- out_ready held low 5 cycles in OUTPUT, in_valid high → out_valid held, in_ready=0, no new start; accept occurs the cycle after IDLE is entered.
- reset low during WAIT of layer 1 → next cycle IDLE, current_layer=0, no further layer_start, no out_valid.
- With LAYER_SEQUENCER_WATCHDOG_EN, TIMEOUT_CYCLES=8, layer 0 never done → error=1 after 8 WAIT cycles, IDLE, in_ready=1, out_valid never asserted.
